// File: rtl/spi_cs_sequencer.sv
// Chip-select sequencer in front of an SPI byte master: groups up to MAX_BYTES_PER_CS
// bytes under one CS_n assertion and guarantees a minimum CS-high gap between groups.
module spi_cs_sequencer #(
  parameter int MAX_BYTES_PER_CS = 4,
  parameter int CS_INACTIVE_CLKS = 1,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic [CW-1:0] o_RX_Count,
  output logic [7:0]    o_M_TX_Byte,
  output logic          o_M_TX_DV,
  input  logic          i_M_TX_Ready,
  input  logic          i_M_RX_DV,
  input  logic [7:0]    i_M_RX_Byte,
  output logic          o_SPI_CS_n,
  output logic [1:0]    o_Dbg_State
);

  // Handshake: a byte is taken on any rising edge where i_TX_DV and o_TX_Ready are
  // both 1; o_TX_Ready is combinational and never depends on i_TX_DV.

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    TRANSFER    = 2'd1,
    CS_HOLD     = 2'd2,
    CS_INACTIVE = 2'd3
  } state_t;

  localparam int IW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_BYTES_PER_CS);
  localparam logic [IW-1:0] INACT_LAST = IW'(CS_INACTIVE_CLKS - 1);

  state_t        r_state, w_next_state;
  logic [CW-1:0] r_count, r_tx_cnt, r_rx_cnt;
  logic [IW-1:0] r_inact_cnt;
  logic          r_busy;
  logic          r_M_TX_DV, r_RX_DV, r_CS_n;
  logic [7:0]    r_M_TX_Byte, r_RX_Byte;
  logic [CW-1:0] r_RX_Count;

  logic          w_tx_ready, w_start, w_send, w_rx_take, w_rx_last;
  logic [CW-1:0] w_count_sat;

  always_comb begin
    w_tx_ready = 1'b0;
    case (r_state)
      IDLE:     w_tx_ready = i_M_TX_Ready && !i_Rst;
      TRANSFER: w_tx_ready = !r_busy && i_M_TX_Ready && !r_M_TX_DV && (r_tx_cnt < r_count);
      default:  w_tx_ready = 1'b0;
    endcase
  end

  assign w_count_sat = (i_TX_Count > MAX_CNT) ? MAX_CNT : i_TX_Count;
  // A zero-count request in IDLE is dropped without touching CS.
  assign w_start   = i_TX_DV && w_tx_ready && (r_state == IDLE) && (i_TX_Count != '0);
  assign w_send    = w_start || (i_TX_DV && w_tx_ready && (r_state == TRANSFER));
  assign w_rx_take = i_M_RX_DV && (r_state == TRANSFER) && (r_rx_cnt < r_count);
  assign w_rx_last = (r_rx_cnt + CW'(1)) == r_count;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:        if (w_start) w_next_state = TRANSFER;
      TRANSFER:    if (w_rx_take && w_rx_last) w_next_state = CS_HOLD;
      CS_HOLD:     if (i_M_TX_Ready) w_next_state = CS_INACTIVE;
      CS_INACTIVE: if (r_inact_cnt == INACT_LAST) w_next_state = IDLE;
      default:     w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_count     <= '0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_inact_cnt <= '0;
      r_busy      <= 1'b0;
      r_M_TX_DV   <= 1'b0;
      r_M_TX_Byte <= '0;
      r_RX_DV     <= 1'b0;
      r_RX_Byte   <= '0;
      r_RX_Count  <= '0;
      r_CS_n      <= 1'b1;
    end else begin
      r_M_TX_DV <= w_send;
      r_RX_DV   <= w_rx_take;

      if (w_start) begin
        r_count  <= w_count_sat;
        r_tx_cnt <= CW'(1);
        r_rx_cnt <= '0;
        r_CS_n   <= 1'b0;
      end else if (w_send) begin
        r_tx_cnt <= r_tx_cnt + CW'(1);
      end

      if (w_send) begin
        r_M_TX_Byte <= i_TX_Byte;
        r_busy      <= 1'b1;
      end else if (w_rx_take) begin
        r_busy <= 1'b0;
      end

      if (w_rx_take) begin
        r_RX_Byte  <= i_M_RX_Byte;
        r_RX_Count <= r_rx_cnt;
        r_rx_cnt   <= r_rx_cnt + CW'(1);
      end

      // CS releases only once the master reports it has finished clocking.
      if (r_state == CS_HOLD && i_M_TX_Ready) r_CS_n <= 1'b1;

      if (r_state == CS_INACTIVE) r_inact_cnt <= r_inact_cnt + IW'(1);
      else                        r_inact_cnt <= '0;
    end
  end

  assign o_TX_Ready  = w_tx_ready;
  assign o_RX_DV     = r_RX_DV;
  assign o_RX_Byte   = r_RX_Byte;
  assign o_RX_Count  = r_RX_Count;
  assign o_M_TX_Byte = r_M_TX_Byte;
  assign o_M_TX_DV   = r_M_TX_DV;
  assign o_SPI_CS_n  = r_CS_n;
  assign o_Dbg_State = r_state;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer: instance a uses defaults, instance b has a
// 3-cycle CS gap. Each instance talks to a loopback SPI master model with 4-cycle latency.
module tb_spi_cs_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic rst = 1'b1;

  // instance a
  logic [2:0] tx_count_a = '0;
  logic [7:0] tx_byte_a = '0;
  logic       tx_dv_a = 1'b0;
  logic       o_tx_ready_a, o_rx_dv_a, o_m_tx_dv_a, o_cs_n_a;
  logic [7:0] o_rx_byte_a, o_m_tx_byte_a;
  logic [2:0] o_rx_count_a;
  logic [1:0] dbg_a;
  logic       m_ready_a = 1'b1, m_rx_dv_a = 1'b0, stray_a = 1'b0;
  logic [7:0] m_rx_byte_a = '0, m_sh_a = '0;
  int         m_cnt_a = 0;

  // instance b
  logic [2:0] tx_count_b = '0;
  logic [7:0] tx_byte_b = '0;
  logic       tx_dv_b = 1'b0;
  logic       o_tx_ready_b, o_rx_dv_b, o_m_tx_dv_b, o_cs_n_b;
  logic [7:0] o_rx_byte_b, o_m_tx_byte_b;
  logic [2:0] o_rx_count_b;
  logic [1:0] dbg_b;
  logic       m_ready_b = 1'b1, m_rx_dv_b = 1'b0;
  logic [7:0] m_rx_byte_b = '0, m_sh_b = '0;
  int         m_cnt_b = 0;

  spi_cs_sequencer dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Count(tx_count_a), .i_TX_Byte(tx_byte_a),
    .i_TX_DV(tx_dv_a), .o_TX_Ready(o_tx_ready_a), .o_RX_DV(o_rx_dv_a),
    .o_RX_Byte(o_rx_byte_a), .o_RX_Count(o_rx_count_a), .o_M_TX_Byte(o_m_tx_byte_a),
    .o_M_TX_DV(o_m_tx_dv_a), .i_M_TX_Ready(m_ready_a), .i_M_RX_DV(m_rx_dv_a | stray_a),
    .i_M_RX_Byte(m_rx_byte_a), .o_SPI_CS_n(o_cs_n_a), .o_Dbg_State(dbg_a)
  );

  spi_cs_sequencer #(.MAX_BYTES_PER_CS(4), .CS_INACTIVE_CLKS(3)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Count(tx_count_b), .i_TX_Byte(tx_byte_b),
    .i_TX_DV(tx_dv_b), .o_TX_Ready(o_tx_ready_b), .o_RX_DV(o_rx_dv_b),
    .o_RX_Byte(o_rx_byte_b), .o_RX_Count(o_rx_count_b), .o_M_TX_Byte(o_m_tx_byte_b),
    .o_M_TX_DV(o_m_tx_dv_b), .i_M_TX_Ready(m_ready_b), .i_M_RX_DV(m_rx_dv_b),
    .i_M_RX_Byte(m_rx_byte_b), .o_SPI_CS_n(o_cs_n_b), .o_Dbg_State(dbg_b)
  );

  // SPI master models: busy 4 cycles per byte, MISO looped back to MOSI.
  always @(negedge clk) begin
    m_rx_dv_a = 1'b0;
    if (rst) begin
      m_cnt_a = 0; m_ready_a = 1'b1;
    end else if (m_cnt_a > 0) begin
      m_cnt_a--;
      if (m_cnt_a == 0) begin m_rx_dv_a = 1'b1; m_rx_byte_a = m_sh_a; m_ready_a = 1'b1; end
    end else if (o_m_tx_dv_a) begin
      m_sh_a = o_m_tx_byte_a; m_cnt_a = 4; m_ready_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    m_rx_dv_b = 1'b0;
    if (rst) begin
      m_cnt_b = 0; m_ready_b = 1'b1;
    end else if (m_cnt_b > 0) begin
      m_cnt_b--;
      if (m_cnt_b == 0) begin m_rx_dv_b = 1'b1; m_rx_byte_b = m_sh_b; m_ready_b = 1'b1; end
    end else if (o_m_tx_dv_b) begin
      m_sh_b = o_m_tx_byte_b; m_cnt_b = 4; m_ready_b = 1'b0;
    end
  end

  // Scoreboard for instance a: bytes issued to the master and bytes returned.
  logic [7:0]  exp_q[$];
  logic [7:0]  txq_a[$];
  logic [10:0] rxq_a[$];
  int cs_rise_a = 0, cs_viol_a = 0, cs_low_a = 0;
  logic cs_prev_a = 1'b1;

  always @(negedge clk) begin
    if (o_m_tx_dv_a) begin
      txq_a.push_back(o_m_tx_byte_a);
      if (o_cs_n_a) cs_viol_a++;
    end
    if (o_rx_dv_a) rxq_a.push_back({o_rx_count_a, o_rx_byte_a});
    if (o_cs_n_a && !cs_prev_a) cs_rise_a++;
    if (!o_cs_n_a) cs_low_a++;
    cs_prev_a = o_cs_n_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_sb();
    exp_q.delete(); txq_a.delete(); rxq_a.delete();
    cs_rise_a = 0; cs_viol_a = 0; cs_low_a = 0;
  endtask

  task automatic wait_ready_a(input string tag);
    int k = 0;
    while (!o_tx_ready_a && k < 50) begin step(); k++; end
    if (k == 50) chk({tag, " ready timeout"}, 32'(o_tx_ready_a), 32'd1);
  endtask

  task automatic send_a(input logic [2:0] cnt, input logic [7:0] b);
    wait_ready_a("send_a");
    tx_dv_a = 1'b1; tx_count_a = cnt; tx_byte_a = b;
    exp_q.push_back(b);
    step();
    tx_dv_a = 1'b0; tx_count_a = '0;
  endtask

  task automatic wait_idle_a(input string tag);
    int k = 0;
    while (!(o_cs_n_a && o_tx_ready_a && dbg_a == 2'd0) && k < 100) begin step(); k++; end
    chk({tag, " back to idle"}, 32'(dbg_a), 32'd0);
  endtask

  task automatic compare_a(input string tag);
    chk({tag, " tx pulses"}, txq_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < txq_a.size(); i++)
      chk({tag, " tx byte"}, 32'(txq_a[i]), 32'(exp_q[i]));
    chk({tag, " rx pulses"}, rxq_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rxq_a.size(); i++) begin
      chk({tag, " rx index"}, 32'(rxq_a[i][10:8]), i);
      chk({tag, " rx byte"}, 32'(rxq_a[i][7:0]), 32'(exp_q[i]));
    end
    chk({tag, " cs rises"}, cs_rise_a, 1);
    chk({tag, " cs low at tx"}, cs_viol_a, 0);
  endtask

  initial begin
    int k, leak, hi, lowrdy, cs_drop;

    // reset values
    step(2);
    chk("rst cs_n", 32'(o_cs_n_a), 32'd1);
    chk("rst tx_ready", 32'(o_tx_ready_a), 32'd0);
    chk("rst m_tx_dv", 32'(o_m_tx_dv_a), 32'd0);
    chk("rst rx_dv", 32'(o_rx_dv_a), 32'd0);
    chk("rst m_tx_byte", 32'(o_m_tx_byte_a), 32'd0);
    chk("rst rx_byte", 32'(o_rx_byte_a), 32'd0);
    chk("rst rx_count", 32'(o_rx_count_a), 32'd0);
    chk("rst state", 32'(dbg_a), 32'd0);
    rst = 1'b0;
    step();
    clear_sb();
    chk("idle tx_ready", 32'(o_tx_ready_a), 32'd1);
    chk("idle cs_n", 32'(o_cs_n_a), 32'd1);

    // single byte, cycle by cycle
    tx_dv_a = 1'b1; tx_count_a = 3'd1; tx_byte_a = 8'hA5; exp_q.push_back(8'hA5);
    step();
    tx_dv_a = 1'b0; tx_count_a = '0;
    chk("t1 m_tx_dv", 32'(o_m_tx_dv_a), 32'd1);
    chk("t1 m_tx_byte", 32'(o_m_tx_byte_a), 32'hA5);
    chk("t1 cs low", 32'(o_cs_n_a), 32'd0);
    chk("t1 busy ready", 32'(o_tx_ready_a), 32'd0);
    k = 0;
    while (!o_rx_dv_a && k < 20) begin step(); k++; end
    chk("t1 rx latency", k, 5);
    chk("t1 rx_byte", 32'(o_rx_byte_a), 32'hA5);
    chk("t1 rx_count", 32'(o_rx_count_a), 32'd0);
    chk("t1 cs hold", 32'(o_cs_n_a), 32'd0);
    chk("t1 hold ready", 32'(o_tx_ready_a), 32'd0);
    step();
    chk("t1 cs release", 32'(o_cs_n_a), 32'd1);
    chk("t1 inactive ready", 32'(o_tx_ready_a), 32'd0);
    step();
    chk("t1 idle ready", 32'(o_tx_ready_a), 32'd1);
    chk("t1 idle cs", 32'(o_cs_n_a), 32'd1);
    compare_a("t1");

    // burst of 3; later bytes carry a junk count that must be ignored
    clear_sb();
    send_a(3'd3, 8'h01);
    send_a(3'd0, 8'h02);
    send_a(3'd1, 8'h03);
    wait_idle_a("burst");
    compare_a("burst");

    // saturation: count 7 limited to 4, extra DV held while not ready
    clear_sb();
    send_a(3'd7, 8'h11);
    send_a(3'd0, 8'h12);
    send_a(3'd0, 8'h13);
    send_a(3'd0, 8'h14);
    tx_dv_a = 1'b1; tx_byte_a = 8'hEE; tx_count_a = 3'd2;
    leak = 0; k = 0;
    while (!o_cs_n_a && k < 60) begin
      if (o_tx_ready_a) leak++;
      step(); k++;
    end
    tx_dv_a = 1'b0; tx_count_a = '0;
    chk("sat ready after 4th", leak, 0);
    wait_idle_a("sat");
    compare_a("sat");

    // zero-count request in idle
    clear_sb();
    tx_dv_a = 1'b1; tx_count_a = 3'd0; tx_byte_a = 8'h77;
    step();
    tx_dv_a = 1'b0;
    step(3);
    chk("cnt0 no m_tx_dv", txq_a.size(), 0);
    chk("cnt0 cs never low", cs_low_a, 0);
    chk("cnt0 state", 32'(dbg_a), 32'd0);

    // stray master RX_DV outside TRANSFER
    stray_a = 1'b1;
    step();
    stray_a = 1'b0;
    step();
    chk("stray no rx_dv", rxq_a.size(), 0);
    chk("stray state", 32'(dbg_a), 32'd0);
    send_a(3'd1, 8'h3C);
    wait_idle_a("post stray");
    compare_a("post stray");

    // reset while sending byte 2 of 3
    clear_sb();
    send_a(3'd3, 8'h21);
    wait_ready_a("mid rst");
    tx_dv_a = 1'b1; tx_count_a = 3'd0; tx_byte_a = 8'h22; rst = 1'b1;
    step();
    tx_dv_a = 1'b0;
    chk("mrst cs_n", 32'(o_cs_n_a), 32'd1);
    chk("mrst m_tx_dv", 32'(o_m_tx_dv_a), 32'd0);
    chk("mrst m_tx_byte", 32'(o_m_tx_byte_a), 32'd0);
    chk("mrst rx_byte", 32'(o_rx_byte_a), 32'd0);
    chk("mrst tx_ready", 32'(o_tx_ready_a), 32'd0);
    chk("mrst state", 32'(dbg_a), 32'd0);
    rst = 1'b0;
    step();
    chk("mrst release ready", 32'(o_tx_ready_a), 32'd1);
    chk("mrst only byte 1 sent", txq_a.size(), 1);
    clear_sb();
    send_a(3'd1, 8'h5C);
    wait_idle_a("after rst");
    compare_a("after rst");

    // instance b: back-to-back transactions with a 3-cycle CS gap
    k = 0;
    while (!o_tx_ready_b && k < 50) begin step(); k++; end
    tx_dv_b = 1'b1; tx_count_b = 3'd1; tx_byte_b = 8'h81;
    step();
    tx_dv_b = 1'b0;
    chk("b1 m_tx_byte", 32'(o_m_tx_byte_b), 32'h81);
    chk("b1 cs low", 32'(o_cs_n_b), 32'd0);
    k = 0;
    while (!o_cs_n_b && k < 60) begin step(); k++; end
    hi = 0; lowrdy = 0; cs_drop = 0; k = 0;
    while (!o_tx_ready_b && k < 60) begin
      if (!o_cs_n_b) cs_drop++;
      lowrdy++; hi++;
      step(); k++;
    end
    chk("b gap ready low", lowrdy, 3);
    chk("b gap cs stayed high", cs_drop, 0);
    hi++;
    tx_dv_b = 1'b1; tx_count_b = 3'd1; tx_byte_b = 8'h82;
    step();
    tx_dv_b = 1'b0;
    chk("b gap >= 3", 32'(hi >= 3), 32'd1);
    chk("b2 cs low", 32'(o_cs_n_b), 32'd0);
    chk("b2 m_tx_byte", 32'(o_m_tx_byte_b), 32'h82);
    k = 0;
    while (!o_rx_dv_b && k < 20) begin step(); k++; end
    chk("b2 rx_byte", 32'(o_rx_byte_b), 32'h82);
    chk("b2 rx_count", 32'(o_rx_count_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_cs_sequencer.md
SPI_CS_SEQUENCER -- requirements
Module: spi_cs_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_BYTES_PER_CS, default 4, setting the max bytes per chip-select assertion (>=1).
REQ-002 The block SHALL have parameter CS_INACTIVE_CLKS, default 1, setting the min i_Clk cycles CS stays high between transactions (>=1).
REQ-003 The block SHALL use CW = $clog2(MAX_BYTES_PER_CS+1) as the count width.
REQ-004 The block SHALL have port i_Clk  input  1  sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_Rst  input  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port i_TX_Count  input  CW  byte count of a transaction; sampled with the first i_TX_DV only.
REQ-007 The block SHALL have port i_TX_Byte  input  8  byte to send; valid with i_TX_DV.
REQ-008 The block SHALL have port i_TX_DV  input  1  byte-valid pulse; accepted only when o_TX_Ready=1.
REQ-009 The block SHALL have port o_TX_Ready  output  1  ready for the next byte.
REQ-010 The block SHALL have port o_RX_DV  output  1  one-cycle pulse per received byte.
REQ-011 The block SHALL have port o_RX_Byte  output  8  received byte.
REQ-012 The block SHALL have port o_RX_Count  output  CW  index of the byte within the transaction (0-based).
REQ-013 The block SHALL have ports o_M_TX_Byte (output, 8), o_M_TX_DV (output, 1), i_M_TX_Ready (input, 1), i_M_RX_DV (input, 1) and i_M_RX_Byte (input, 8), connected to the SPI master byte interface.
REQ-014 The block SHALL have port o_SPI_CS_n  output  1  chip select, active low.

Function
REQ-015 The block SHALL implement states IDLE, TRANSFER, CS_HOLD and CS_INACTIVE.
REQ-016 In IDLE, o_TX_Ready SHALL equal i_M_TX_Ready and o_SPI_CS_n SHALL be 1.
REQ-017 When i_TX_DV=1 in IDLE and i_TX_Count is nonzero, the block SHALL:
- latch the count, saturated to MAX_BYTES_PER_CS;
- register i_TX_Byte into o_M_TX_Byte;
- on the next edge, pulse o_M_TX_DV for one cycle and drive o_SPI_CS_n=0;
- enter TRANSFER.
REQ-018 When i_TX_DV=1 in IDLE with i_TX_Count=0, the block SHALL ignore it: no CS assertion, no o_M_TX_DV.
REQ-019 The block SHALL keep a busy flag:
- set on each o_M_TX_DV issue;
- cleared on i_M_RX_DV.
REQ-020 In TRANSFER, o_TX_Ready SHALL be 1 only when all of the following hold: busy=0, i_M_TX_Ready=1, o_M_TX_DV=0, bytes sent < latched count.
REQ-021 For each accepted byte in TRANSFER, the block SHALL register it and pulse o_M_TX_DV one cycle later; o_SPI_CS_n SHALL stay 0.
REQ-022 The block SHALL register each i_M_RX_DV to o_RX_DV one cycle later, with i_M_RX_Byte to o_RX_Byte and the current receive index to o_RX_Count; the receive index SHALL increment after each.
REQ-023 On i_M_RX_DV for byte index count-1, the block SHALL enter CS_HOLD.
REQ-024 In CS_HOLD, o_TX_Ready SHALL be 0 and o_SPI_CS_n SHALL be 0 until i_M_TX_Ready=1; the next edge SHALL then drive o_SPI_CS_n=1 and enter CS_INACTIVE.
REQ-025 In CS_INACTIVE, o_SPI_CS_n SHALL be 1 and o_TX_Ready SHALL be 0 for exactly CS_INACTIVE_CLKS cycles, then the block SHALL enter IDLE.
REQ-026 The block SHALL ignore i_TX_DV whenever o_TX_Ready=0, and SHALL ignore i_TX_Count on every byte after the first.
REQ-027 The block SHALL ignore i_M_RX_DV outside TRANSFER; it SHALL NOT generate o_RX_DV or change state.
REQ-028 The TRANSFER sent and received counters SHALL never exceed the latched count; no wrap-around is permitted.

Reset
REQ-029 While i_Rst=1 at a clock edge, the block SHALL set the following on that edge: state=IDLE, o_SPI_CS_n=1, o_TX_Ready=0, o_M_TX_DV=0, o_RX_DV=0, o_M_TX_Byte=0, o_RX_Byte=0, o_RX_Count=0, busy=0, all counters=0.
REQ-030 The block SHALL handle reset mid-transaction per REQ-029 on the same edge, with no further o_M_TX_DV; o_TX_Ready SHALL follow REQ-016 from the first cycle after reset release.

Verification
REQ-031 The bench SHALL cover a single byte: count=1, byte 0xA5, MISO loopback -> one o_M_TX_DV with 0xA5, CS low before the first SPI edge, o_RX_DV with 0xA5 and o_RX_Count=0, CS high after the master is ready, o_TX_Ready low for 1 cycle, then IDLE.
REQ-032 The bench SHALL cover a burst: count=3, bytes 0x01/0x02/0x03 sent back-to-back at each o_TX_Ready -> CS stays low throughout, o_RX_Count 0,1,2, exactly 3 o_M_TX_DV pulses.
REQ-033 The bench SHALL cover saturation: count=7 with MAX=4 -> exactly 4 bytes are accepted; o_TX_Ready=0 after the 4th, then CS deasserts.
REQ-034 The bench SHALL cover illegal requests: i_TX_DV with count=0 in IDLE -> no CS and no o_M_TX_DV; i_TX_DV while o_TX_Ready=0 -> no effect.
REQ-035 The bench SHALL cover mid-transaction reset: i_Rst asserted while sending byte 2 of 3 -> o_SPI_CS_n=1 and all outputs at reset values on that edge; a new count=1 transaction then completes normally.
REQ-036 The bench SHALL cover CS_INACTIVE_CLKS=3: back-to-back transactions -> o_SPI_CS_n high for at least 3 cycles between them.
